axis_pkt_fifo: RTL and testbench

//  Per-port store-and-forward packet FIFO; sits directly downstream of bus_cross_bar and consumes one fifo_m_axis_N stream.

---
 rtl/axis_fifo_pkg.sv | 15 +
 rtl/axis_fifo_ram.sv | 25 ++
 rtl/axis_pkt_fifo.sv | 159 +++++++++++++++
 tb/tb_axis_pkt_fifo.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared definitions for the AXI-Stream packet FIFO: width defaults, write-side
// state encoding and drop counter width.
package axis_fifo_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int KEEP_W_DEF = DATA_W_DEF / 8;
    localparam int DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_PKT  = 2'd1,
        WR_DROP = 2'd2
    } wr_state_e;

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage for the packet FIFO: synchronous write, asynchronous read.
module axis_fifo_ram #(
    parameter int WIDTH  = 37,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO. Define AXIS_PKT_FIFO_DROP_EN to drop
// packets that overflow instead of back-pressuring and cutting through.
module axis_pkt_fifo
    import axis_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int KEEP_W = KEEP_W_DEF,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  glb_clk,
    input  logic                  glb_reset,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [KEEP_W-1:0]     s_axis_tkeep,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [KEEP_W-1:0]     m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic [ADDR_W:0]       fifo_level,
    output logic [ADDR_W:0]       pkt_count,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int ENT_W = DATA_W + KEEP_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    wr_state_e        state_q;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] wr_cur_q, wr_cur_d;
    logic [PTR_W-1:0] pkt_count_q, pkt_count_d;
    logic [PTR_W-1:0] level_q;
    logic             release_q;
    logic             full, empty, s_hs, m_hs, wr_en, rd_last;
    logic [ENT_W-1:0] wr_entry, rd_entry;

    assign full  = (wr_cur_q - rd_ptr_q) == DEPTH_P;
    assign empty = (rd_ptr_q == wr_cur_q);

    assign s_hs = s_axis_tvalid & s_axis_tready;
    assign m_hs = m_axis_tvalid & m_axis_tready;

    assign m_axis_tvalid = !glb_reset && ((pkt_count_q != '0) || (release_q && !empty));

    assign wr_entry = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = rd_entry;
    assign rd_last  = rd_entry[0];

    assign fifo_level = level_q;
    assign pkt_count  = pkt_count_q;

`ifdef AXIS_PKT_FIFO_DROP_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic                  rewind;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign s_axis_tready = !glb_reset;
    // An overflowing beat discards the whole partial packet, not just itself.
    assign wr_en    = s_hs && !full && (state_q != WR_DROP);
    assign rewind   = s_hs && full && (state_q != WR_DROP);
    assign drop_cnt = drop_cnt_q;
`else
    assign s_axis_tready = !glb_reset && !full;
    assign wr_en         = s_hs;
    assign drop_cnt      = '0;
`endif

    axis_fifo_ram #(
        .WIDTH  (ENT_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (glb_clk),
        .we_i    (wr_en),
        .waddr_i (wr_cur_q[ADDR_W-1:0]),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rd_entry)
    );

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(m_hs);
        wr_cur_d = wr_cur_q;
        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            wr_cur_d = wr_cur_q + 1'b1;
            if (s_axis_tlast) begin
                wr_ptr_d = wr_cur_q + 1'b1;
            end
        end
`ifdef AXIS_PKT_FIFO_DROP_EN
        if (rewind) begin
            wr_cur_d = wr_ptr_q;
        end
`endif
        // A commit and a tlast read in the same cycle cancel out.
        pkt_count_d = pkt_count_q + PTR_W'(wr_en && s_axis_tlast) - PTR_W'(m_hs && rd_last);
    end

    always_ff @(posedge glb_clk) begin
        if (glb_reset) begin
            state_q     <= WR_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            wr_cur_q    <= '0;
            pkt_count_q <= '0;
            level_q     <= '0;
            release_q   <= 1'b0;
`ifdef AXIS_PKT_FIFO_DROP_EN
            drop_cnt_q  <= '0;
`endif
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_cur_q    <= wr_cur_d;
            pkt_count_q <= pkt_count_d;
            level_q     <= wr_cur_d - rd_ptr_d;
`ifdef AXIS_PKT_FIFO_DROP_EN
            case (state_q)
                WR_DROP: begin
                    if (s_hs && s_axis_tlast) begin
                        state_q    <= WR_IDLE;
                        drop_cnt_q <= sat_inc(drop_cnt_q);
                    end
                end
                default: begin
                    if (rewind) begin
                        state_q <= s_axis_tlast ? WR_IDLE : WR_DROP;
                        if (s_axis_tlast) begin
                            drop_cnt_q <= sat_inc(drop_cnt_q);
                        end
                    end else if (wr_en) begin
                        state_q <= s_axis_tlast ? WR_IDLE : WR_PKT;
                    end
                end
            endcase
`else
            if (wr_en) begin
                state_q <= s_axis_tlast ? WR_IDLE : WR_PKT;
            end
            // A packet larger than the buffer would deadlock; let it cut through.
            if (full && (state_q == WR_PKT) && (pkt_count_q == '0)) begin
                release_q <= 1'b1;
            end else if (m_hs && rd_last) begin
                release_q <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Randomized bench for axis_pkt_fifo (DEPTH=16) against a queue-based packet model.
// Honours AXIS_PKT_FIFO_DROP_EN for the drop-mode scenario.
module tb_axis_pkt_fifo;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        glb_reset = 1'b1;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic [4:0]  fifo_level;
    logic [4:0]  pkt_count;
    logic [15:0] drop_cnt;

    axis_pkt_fifo #(.DATA_W(32), .KEEP_W(4), .DEPTH(DEPTH), .ADDR_W(4)) dut (
        .glb_clk       (clk),
        .glb_reset     (glb_reset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .fifo_level    (fifo_level),
        .pkt_count     (pkt_count),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Model: every stored beat in arrival order, plus packet bookkeeping.
    beat_t st[$];
    int    pkt_m = 0, part_m = 0, dcnt_m = 0;
    bit    rel_m = 1'b0, drop_m = 1'b0, acc_in = 1'b0;

    // Stimulus: queue of beats to offer upstream.
    beat_t in_q[$];
    beat_t cur;
    bit    pend = 1'b0;
    int    out_cnt = 0;
    int    last_pos[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit drop_mode();
`ifdef AXIS_PKT_FIFO_DROP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        int    lvl, pre_pkt, pre_part;
        bit    full, ev, er, hs_out, hs_in;
        beat_t b;
        if (glb_reset) begin
            st.delete();
            pkt_m = 0; part_m = 0; dcnt_m = 0;
            rel_m = 1'b0; drop_m = 1'b0; acc_in = 1'b0;
        end else begin
            lvl      = st.size();
            full     = (lvl == DEPTH);
            er       = drop_mode() ? 1'b1 : !full;
            ev       = (pkt_m != 0) || (rel_m && lvl != 0);
            hs_out   = ev && m_axis_tready;
            hs_in    = s_axis_tvalid && er;
            acc_in   = hs_in;
            pre_pkt  = pkt_m;
            pre_part = part_m;
            if (hs_out) begin
                b = st.pop_front();
                if (b.l) begin
                    pkt_m--;
                    rel_m = 1'b0;
                end
            end
            if (drop_mode()) begin
                if (drop_m) begin
                    if (hs_in && s_axis_tlast) begin
                        drop_m = 1'b0;
                        if (dcnt_m < 65535) dcnt_m++;
                    end
                    hs_in = 1'b0;
                end else if (hs_in && full) begin
                    repeat (pre_part) void'(st.pop_back());
                    part_m = 0;
                    if (s_axis_tlast) begin
                        if (dcnt_m < 65535) dcnt_m++;
                    end else begin
                        drop_m = 1'b1;
                    end
                    hs_in = 1'b0;
                end
            end else if (full && pre_part != 0 && pre_pkt == 0) begin
                rel_m = 1'b1;
            end
            if (hs_in) begin
                st.push_back('{d: s_axis_tdata, k: s_axis_tkeep, l: s_axis_tlast});
                if (s_axis_tlast) begin
                    pkt_m++;
                    part_m = 0;
                end else begin
                    part_m++;
                end
            end
        end
    end

    always @(negedge clk) begin
        int lvl;
        bit ev, er;
        if (chk_en) begin
            lvl = st.size();
            ev  = !glb_reset && ((pkt_m != 0) || (rel_m && lvl != 0));
            er  = !glb_reset && (drop_mode() || lvl != DEPTH);
            chk("s_axis_tready", 32'(s_axis_tready), 32'(er));
            chk("m_axis_tvalid", 32'(m_axis_tvalid), 32'(ev));
            chk("fifo_level", 32'(fifo_level), 32'(lvl));
            chk("pkt_count", 32'(pkt_count), 32'(pkt_m));
            chk("drop_cnt", 32'(drop_cnt), 32'(dcnt_m));
            if (ev) begin
                chk("m_axis_tdata", m_axis_tdata, st[0].d);
                chk("m_axis_tkeep", 32'(m_axis_tkeep), 32'(st[0].k));
                chk("m_axis_tlast", 32'(m_axis_tlast), 32'(st[0].l));
            end
            if (m_axis_tvalid && m_axis_tready && !glb_reset) begin
                out_cnt++;
                if (m_axis_tlast) last_pos.push_back(out_cnt);
            end
        end
    end

    task automatic push_pkt(input int len, input bit with_last);
        for (int i = 0; i < len; i++) begin
            in_q.push_back('{d: $urandom, k: 4'($urandom_range(15)),
                             l: with_last && (i == len - 1)});
        end
    endtask

    task automatic cyc(input int pin, input bit rdy);
        @(posedge clk);
        #1;
        if (pend && acc_in) pend = 1'b0;
        if (!pend && in_q.size() != 0 && $urandom_range(99) < pin) begin
            cur  = in_q.pop_front();
            pend = 1'b1;
        end
        s_axis_tvalid = pend;
        s_axis_tdata  = cur.d;
        s_axis_tkeep  = cur.k;
        s_axis_tlast  = cur.l;
        m_axis_tready = rdy;
    endtask

    task automatic wait_idle(input string nm, input int max, input int pin, input bit rdy);
        bit done;
        done = 1'b0;
        for (int n = 0; n < max && !done; n++) begin
            cyc(pin, rdy);
            if (in_q.size() == 0 && !pend) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s: upstream still busy after %0d cycles", nm, max);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] first_d;
        bit          hit;

        // Reset state
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_pkt", 32'(pkt_count), 32'd0);
        @(posedge clk);
        #1 glb_reset = 1'b0;

        // Single 4-beat packet: valid only after tlast is stored
        push_pkt(4, 1'b1);
        first_d = in_q[0].d;
        out_cnt = 0; last_pos.delete();
        for (int i = 0; i < 4; i++) begin
            cyc(100, 1'b1);
            @(negedge clk);
            chk("p4_early_tvalid", 32'(m_axis_tvalid), 32'd0);
        end
        cyc(100, 1'b1);
        @(negedge clk);
        chk("p4_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("p4_pkt", 32'(pkt_count), 32'd1);
        chk("p4_first_data", m_axis_tdata, first_d);
        repeat (6) cyc(0, 1'b1);
        @(negedge clk);
        chk("p4_beats_out", 32'(out_cnt), 32'd4);
        chk("p4_last_pos", 32'(last_pos.size() == 1 ? last_pos[0] : -1), 32'd4);
        chk("p4_pkt_end", 32'(pkt_count), 32'd0);

        // Three 3-beat packets held back, then released
        for (int p = 0; p < 3; p++) push_pkt(3, 1'b1);
        wait_idle("p3x3_fill", 100, 100, 1'b0);
        cyc(0, 1'b0);
        @(negedge clk);
        chk("p3x3_pkt", 32'(pkt_count), 32'd3);
        chk("p3x3_level", 32'(fifo_level), 32'd9);
        out_cnt = 0; last_pos.delete();
        repeat (15) cyc(0, 1'b1);
        @(negedge clk);
        chk("p3x3_beats_out", 32'(out_cnt), 32'd9);
        chk("p3x3_last_cnt", 32'(last_pos.size()), 32'd3);
        if (last_pos.size() == 3) begin
            chk("p3x3_last1", 32'(last_pos[0]), 32'd3);
            chk("p3x3_last2", 32'(last_pos[1]), 32'd6);
            chk("p3x3_last3", 32'(last_pos[2]), 32'd9);
        end

`ifdef AXIS_PKT_FIFO_DROP_EN
        // Overflowing second packet is dropped whole
        push_pkt(10, 1'b1);
        push_pkt(12, 1'b1);
        wait_idle("drop_fill", 100, 100, 1'b0);
        cyc(0, 1'b0);
        @(negedge clk);
        chk("drop_cnt_lit", 32'(drop_cnt), 32'd1);
        chk("drop_level", 32'(fifo_level), 32'd10);
        chk("drop_pkt", 32'(pkt_count), 32'd1);
        repeat (14) cyc(0, 1'b1);
`else
        // Oversize packet cuts through once the buffer is full
        out_cnt = 0; last_pos.delete();
        push_pkt(20, 1'b1);
        hit = 1'b0;
        for (int n = 0; n < 60 && !hit; n++) begin
            cyc(100, 1'b0);
            if (fifo_level == 5'd16 && !s_axis_tready) hit = 1'b1;
        end
        @(negedge clk);
        chk("big_level", 32'(fifo_level), 32'd16);
        chk("big_tready", 32'(s_axis_tready), 32'd0);
        cyc(100, 1'b0);
        @(negedge clk);
        chk("big_release_tvalid", 32'(m_axis_tvalid), 32'd1);
        wait_idle("big_drain", 100, 100, 1'b1);
        repeat (20) cyc(0, 1'b1);
        @(negedge clk);
        chk("big_beats_out", 32'(out_cnt), 32'd20);
        chk("big_last_pos", 32'(last_pos.size() == 1 ? last_pos[0] : -1), 32'd20);
`endif

        // Commit and tlast read on the same edge
        push_pkt(2, 1'b1);
        wait_idle("same_fill", 20, 100, 1'b0);
        push_pkt(2, 1'b1);
        first_d = in_q[0].d;
        cyc(100, 1'b1);
        cyc(100, 1'b1);
        cyc(100, 1'b0);
        @(negedge clk);
        chk("same_pkt", 32'(pkt_count), 32'd1);
        chk("same_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("same_data", m_axis_tdata, first_d);
        repeat (4) cyc(0, 1'b1);

        // Reset in the middle of a packet
        push_pkt(7, 1'b0);
        wait_idle("rst_fill", 30, 100, 1'b0);
        cyc(0, 1'b0);
        @(negedge clk);
        chk("mid_level", 32'(fifo_level), 32'd7);
        @(posedge clk);
        #1 glb_reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_tready", 32'(s_axis_tready), 32'd0);
        chk("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        @(posedge clk);
        #1 glb_reset = 1'b0;
        in_q.delete();
        pend = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("post_rst_level", 32'(fifo_level), 32'd0);
        chk("post_rst_pkt", 32'(pkt_count), 32'd0);
        chk("post_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("post_rst_tready", 32'(s_axis_tready), 32'd1);

        // Random traffic, packets up to 20 beats
        for (int c = 0; c < 4000; c++) begin
            if (in_q.size() < 8) push_pkt($urandom_range(20, 1), 1'b1);
            cyc(70, $urandom_range(99) < 60);
        end
        repeat (100) cyc(100, 1'b1);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
